// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 round helpers: rcon, GF(2^8) xtime, MixColumns, ShiftRows
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_BYTES  = 16;
  localparam int NUM_WORDS  = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  // Round constant for key expansion of round r (1..10); 0 outside that range.
  function automatic byte_t rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 is the most significant byte.
  function automatic word_t mix_column(input word_t col);
    byte_t a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; row r of column c is byte 4c+r.
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < NUM_WORDS; c++) begin
      for (int r = 0; r < NUM_WORDS; r++) begin
        o[127 - BYTE_W * (NUM_WORDS * c + r) -: BYTE_W] =
          s[127 - BYTE_W * (NUM_WORDS * ((c + r) % NUM_WORDS) + r) -: BYTE_W];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] q
);

  // Entry for input value v is at bits [8*(255-v) +: 8]; row 0 of the table is the MSB end.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign q = SBOX_TABLE[{~a, 3'b000} +: BYTE_W];

endmodule

// File: rtl/enc_aes.sv
// rtl/enc_aes.sv - iterative AES-128 encryptor, one round per clock, fixed key
module enc_aes
  import aes_pkg::*;
#(
  parameter logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  logic [127:0] state;
  logic [127:0] rkey;
  logic [3:0]   round;

  logic [127:0] round_in;
  logic [127:0] key_in;
  logic [7:0]   rc;
  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  key_t;
  logic [127:0] key_next;
  logic [127:0] round_out;
  logic [127:0] final_out;

  // When idle the first AddRoundKey is folded in front of round 1.
  assign round_in = busy ? state : (data_in ^ KEY);
  assign key_in   = busy ? rkey : KEY;
  assign rc       = rcon(busy ? round : 4'd1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_state_sbox
      aes_sbox u_sbox (
        .a (round_in[127 - BYTE_W * gi -: BYTE_W]),
        .q (sub_bytes[127 - BYTE_W * gi -: BYTE_W])
      );
    end
  endgenerate

  // RotWord of the last key word feeds SubWord.
  assign rot_word = {key_in[23:0], key_in[31:24]};

  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_key_sbox
      aes_sbox u_sbox (
        .a (rot_word[31 - BYTE_W * gi -: BYTE_W]),
        .q (sub_word[31 - BYTE_W * gi -: BYTE_W])
      );
    end
  endgenerate

  assign key_t              = sub_word ^ {rc, 24'h000000};
  assign key_next[127:96]   = key_in[127:96] ^ key_t;
  assign key_next[95:64]    = key_in[95:64]  ^ key_next[127:96];
  assign key_next[63:32]    = key_in[63:32]  ^ key_next[95:64];
  assign key_next[31:0]     = key_in[31:0]   ^ key_next[63:32];

  assign shifted = shift_rows(sub_bytes);

  // MixColumns applied independently to each of the four columns.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < NUM_WORDS; c++) begin
      mixed[127 - WORD_W * c -: WORD_W] = mix_column(shifted[127 - WORD_W * c -: WORD_W]);
    end
  end

  assign round_out = mixed ^ key_next;
  assign final_out = shifted ^ key_next;

  // Round sequencer: start loads round 1, rounds 2..9 iterate, round 10 publishes the ciphertext.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= '0;
      rkey     <= KEY;
      round    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          state <= round_out;
          rkey  <= key_next;
          round <= 4'd2;
          busy  <= 1'b1;
        end
      end else if (round == 4'(NUM_ROUNDS)) begin
        data_out <= final_out;
        done     <= 1'b1;
        busy     <= 1'b0;
        round    <= 4'd0;
      end else begin
        state <= round_out;
        rkey  <= key_next;
        round <= round + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_enc_aes.sv
// tb/tb_enc_aes.sv - directed self-checking bench for enc_aes
module tb_enc_aes;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C = 128'h11111111000000001111111100000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start0, start1;
  logic [127:0] data0, data1;
  logic [127:0] data_out0, data_out1;
  logic         busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  enc_aes #(.KEY(KEY0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .data_in(data0),
    .data_out(data_out0), .busy(busy0), .done(done0)
  );

  enc_aes #(.KEY(KEY1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1),
    .data_out(data_out1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference AES-128: S-box from GF inverse plus affine map, full key schedule up front.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [31:0]  tmp;
    logic [7:0]   rcv;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0]), sbox_ref(tmp[31:24])}
              ^ {rcv, 24'h000000};
        rcv = gmul(rcv, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_ref(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4 * c + r];
          for (int r = 0; r < 4; r++)
            s[4 * c + r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r + 1) % 4]) ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
    end
    ct = '0;
    for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
    return ct;
  endfunction

  // Start one block on dut0 and observe 14 edges after the start edge; optional stray starts before edges 3 and 7.
  task automatic run0(input logic [127:0] pt, input bit inject,
                      output int done_edge, output int ndone, output int nbusy, output logic [127:0] q);
    done_edge = 0;
    ndone     = 0;
    nbusy     = 0;
    q         = '0;
    data0     = pt;
    start0    = 1'b1;
    tick();
    start0    = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (busy0) nbusy++;
      if (done0) begin
        ndone++;
        if (done_edge == 0) begin
          done_edge = k;
          q = data_out0;
        end
      end
      if (inject && (k == 2 || k == 6)) begin
        start0 = 1'b1;
        data0  = ~pt;
      end else begin
        start0 = 1'b0;
        data0  = pt;
      end
      tick();
    end
  endtask

  int           de, nd, nb;
  logic [127:0] q;
  logic [127:0] exp_c, exp_b2;

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = '0;
    data1  = '0;
    exp_c  = aes_ref(KEY0, PT_C);
    exp_b2 = aes_ref(KEY0, PT_B);
    tick();
    tick();
    chk("reset_data_out", data_out0, '0);
    chk("reset_done", {127'd0, done0}, '0);
    chk("reset_busy", {127'd0, busy0}, '0);
    chk("reset_data_out_k1", data_out1, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {127'd0, busy0}, '0);

    // FIPS-197 C.1 vector with the default key.
    run0(PT_A, 1'b0, de, nd, nb, q);
    chk_int("a_done_edge", de, 10);
    chk_int("a_done_count", nd, 1);
    chk_int("a_busy_len", nb, 9);
    chk("a_data", q, CT_A);
    chk("a_data_held", data_out0, CT_A);

    // FIPS-197 Appendix B vector on the instance with the alternate key.
    data1  = PT_B;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    de = 0;
    q  = '0;
    for (int k = 1; k <= 14; k++) begin
      if (done1 && de == 0) begin
        de = k;
        q  = data_out1;
      end
      tick();
    end
    chk_int("b_done_edge", de, 10);
    chk("b_data", q, CT_B);

    // Reset while idle clears the held ciphertext, then a fresh block.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("c_reset_data_out", data_out0, '0);
    chk("c_reset_done", {127'd0, done0}, '0);
    chk("c_reset_busy", {127'd0, busy0}, '0);
    run0(PT_C, 1'b0, de, nd, nb, q);
    chk_int("c_done_edge", de, 10);
    chk("c_data", q, exp_c);

    // Starts during an active block are ignored.
    run0(PT_B, 1'b1, de, nd, nb, q);
    chk_int("d_done_count", nd, 1);
    chk_int("d_done_edge", de, 10);
    chk("d_data", q, exp_b2);

    // Reset on edge 5 of a block aborts it.
    data0  = PT_A;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("e_abort_busy", {127'd0, busy0}, '0);
    chk("e_abort_data_out", data_out0, '0);
    chk("e_abort_done", {127'd0, done0}, '0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done0) nd++;
      tick();
    end
    chk_int("e_no_done", nd, 0);
    run0(PT_A, 1'b0, de, nd, nb, q);
    chk("e_fresh_data", q, CT_A);

    // Back-to-back: second start the cycle after done.
    data0  = PT_C;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    chk("f_first_done", {127'd0, done0}, 128'd1);
    chk("f_first_data", data_out0, exp_c);
    data0  = PT_A;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("f_second_busy", {127'd0, busy0}, 128'd1);
    chk("f_hold_early", data_out0, exp_c);
    for (int k = 12; k <= 19; k++) tick();
    chk("f_hold_late", data_out0, exp_c);
    chk("f_no_early_done", {127'd0, done0}, '0);
    tick();
    chk("f_second_done", {127'd0, done0}, 128'd1);
    chk("f_second_data", data_out0, CT_A);
    tick();
    chk("f_done_single", {127'd0, done0}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
